sd_sector_streamer: RTL and testbench
=====================================

SD_SECTOR_STREAMER -- requirements
Module: sd_sector_streamer

Interface
REQ-001 SHALL have parameter BANKS, default 2, number of 512-byte sector buffers (legal: 2 or 4).
REQ-002 SHALL have port clk  input  1  system clock, shared with the sector reader.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports start input 1 (job request pulse), first_sector input 32 (first sector number), sector_count input 16 (sectors in job), abort input 1 (cancel pulse).
REQ-005 SHALL have ports busy output 1 (job active) and done output 1 (one-cycle pulse on job completion or abort completion).
REQ-006 SHALL have reader-side ports: rd_start output 1, rd_sector_no output 32, rd_busy input 1, rd_done input 1, in_req input 1, in_addr input 9, in_byte input 8.
REQ-007 SHALL have stream ports: m_valid output 1, m_ready input 1, m_data output 8, m_sos output 1 (first byte of a sector), m_last output 1 (final byte of the job).

Function
REQ-008 SHALL use states IDLE, RUN and ABORT_WAIT.
REQ-009 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-010 start with sector_count=0 SHALL pulse done on the next cycle, issue no reads and leave busy low.
REQ-011 busy SHALL be high from the cycle after an accepted start until the cycle done pulses.
REQ-012 rd_start SHALL pulse for one cycle in RUN when: rd_busy=0, no read is outstanding, sectors remain unissued, and a free bank exists.
REQ-013 rd_sector_no SHALL equal first_sector + issue index (modulo 2^32), held stable from rd_start until rd_done.
REQ-014 When in_req=1, in_byte SHALL be written to write-bank[in_addr]; in_req with no outstanding read SHALL be ignored.
REQ-015 rd_done SHALL mark the write bank full and advance the write bank modulo BANKS.
REQ-016 Banks SHALL be drained in fill order, bytes addresses 0..511; a bank SHALL become free in the cycle after its byte 511 handshakes.
REQ-017 Stream SHALL follow valid/ready: a byte transfers when m_valid&m_ready; while m_valid=1 and m_ready=0, m_valid, m_data, m_sos and m_last SHALL hold.
REQ-018 With m_ready held high and a full bank, throughput SHALL be 1 byte/cycle, and first m_valid SHALL appear ≤2 cycles after that bank's rd_done.
REQ-019 m_sos SHALL be high on address-0 bytes; m_last SHALL be high only on byte 511 of sector sector_count-1.
REQ-020 done SHALL pulse in the cycle after the m_last handshake; the block SHALL then return to IDLE.
REQ-021 abort in RUN with a read outstanding SHALL go to ABORT_WAIT; done SHALL pulse and the state SHALL become IDLE in the cycle after rd_done.
REQ-022 abort in RUN with no read outstanding SHALL pulse done and go to IDLE in the next cycle.
REQ-023 On abort, all banks SHALL be freed and m_valid SHALL drop in the next cycle; abort in IDLE SHALL be ignored.
REQ-024 If rd_done and a drain-free event occur in the same cycle, both SHALL take effect; bank occupancy count SHALL never exceed BANKS.

Reset
REQ-025 Reset SHALL force state IDLE, all banks free, bank pointers 0, and counters 0.
REQ-026 While rst_n is low, busy, done, rd_start, m_valid, m_sos and m_last SHALL be 0, and rd_sector_no and m_data SHALL be 0.
REQ-027 Reset asserted mid-job SHALL discard buffered data without requiring rd_done.

Structure
REQ-028 Shared package sd_pkg SHALL hold SECTOR_BYTES=512 and the state enum type.
REQ-029 Buffer memory SHALL be sub-module sector_bank_ram: simple dual-port RAM, BANKS×512×8, synchronous read, no reset on contents.

Verification
REQ-030 start, first_sector=100, sector_count=3, m_ready=1 -> rd_sector_no sequence 100,101,102; 1536 bytes in order; m_sos on bytes 0/512/1024; m_last on byte 1535; one done pulse.
REQ-031 first_sector=0xFFFFFFFF, sector_count=2 -> rd_sector_no values 0xFFFFFFFF then 0x00000000.
REQ-032 m_ready=0, sector_count=4, BANKS=2 -> exactly 2 rd_start pulses until the stream is drained, and no byte is lost or duplicated after m_ready rises.
REQ-033 Random m_ready (50%) -> output data equals the written pattern (byte = addr ^ sector[7:0]); m_data is stable while stalled.
REQ-034 abort mid-read of sector 2 of 5 -> ABORT_WAIT until rd_done, then one done pulse, m_valid=0, and no further rd_start.
REQ-035 sector_count=0 -> done pulses the next cycle and no rd_start occurs; rst_n low mid-job -> all outputs are 0 and a new start succeeds.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector streamer: sector geometry and FSM states.
package sd_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int BYTE_ADDR_W  = 9;
   localparam logic [BYTE_ADDR_W-1:0] LAST_BYTE = BYTE_ADDR_W'(SECTOR_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ABORT_WAIT
   } state_t;

endpackage

// File: rtl/sector_bank_ram.sv
// Simple dual-port byte RAM holding all sector banks; one write port fed by the
// reader, one synchronous read port feeding the stream. Contents are not reset.
module sector_bank_ram
   import sd_pkg::*;
#(
   parameter int BANKS = 2,
   parameter int AW    = $clog2(BANKS * SECTOR_BYTES)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [BANKS*SECTOR_BYTES];

   // Capture reader bytes into the addressed bank slot.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read; rdata holds its value whenever re is low so a stalled
   // stream byte stays stable.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sd_sector_streamer.sv
// Multi-bank sector streamer: issues sector reads to an SD reader, buffers each
// sector in a free bank and drains full banks, in fill order, onto a
// valid/ready byte stream.
module sd_sector_streamer
   import sd_pkg::*;
#(
   parameter int BANKS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] first_sector,
   input  logic [15:0] sector_count,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        rd_start,
   output logic [31:0] rd_sector_no,
   input  logic        rd_busy,
   input  logic        rd_done,
   input  logic        in_req,
   input  logic [8:0]  in_addr,
   input  logic [7:0]  in_byte,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_data,
   output logic        m_sos,
   output logic        m_last
);

   localparam int BW     = (BANKS > 2) ? 2 : 1;
   localparam int RAM_AW = BW + BYTE_ADDR_W;

   state_t                 state;
   logic [31:0]            first_r;
   logic [15:0]            count_r;
   logic [15:0]            issued;
   logic [15:0]            fetched;
   logic                   outstanding;
   logic [BW-1:0]          wr_bank;
   logic [BW-1:0]          fetch_bank;
   logic [BYTE_ADDR_W-1:0] fetch_addr;
   logic [2:0]             occupancy;
   logic [2:0]             ready_cnt;
   logic                   out_end;
   logic [7:0]             ram_rdata;

   logic ram_we;
   logic advance;
   logic fetch;
   logic fetch_end;
   logic handshake;
   logic bank_freed;
   logic last_hs;
   logic fill_done;
   logic issue_ok;

   function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
      return (b == BW'(BANKS - 1)) ? '0 : b + BW'(1);
   endfunction

   assign ram_we     = in_req && outstanding && (state == RUN);
   assign advance    = !m_valid || m_ready;
   assign fetch      = (state == RUN) && (ready_cnt != 3'd0) && advance;
   assign fetch_end  = fetch && (fetch_addr == LAST_BYTE);
   assign handshake  = m_valid && m_ready;
   assign bank_freed = handshake && out_end;
   assign last_hs    = handshake && m_last;
   assign fill_done  = rd_done && outstanding;
   assign issue_ok   = (state == RUN) && !rd_busy && !outstanding &&
                       (issued < count_r) && (int'(occupancy) < BANKS);

   assign m_data = m_valid ? ram_rdata : 8'd0;

   sector_bank_ram #(
      .BANKS (BANKS),
      .AW    (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr ({wr_bank, in_addr}),
      .wdata (in_byte),
      .re    (fetch),
      .raddr ({fetch_bank, fetch_addr}),
      .rdata (ram_rdata)
   );

   // Job FSM: read issue, bank bookkeeping, stream output register and
   // completion/abort handling all live here so every output is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         rd_start     <= 1'b0;
         rd_sector_no <= '0;
         first_r      <= '0;
         count_r      <= '0;
         issued       <= '0;
         fetched      <= '0;
         outstanding  <= 1'b0;
         wr_bank      <= '0;
         fetch_bank   <= '0;
         fetch_addr   <= '0;
         occupancy    <= '0;
         ready_cnt    <= '0;
         m_valid      <= 1'b0;
         m_sos        <= 1'b0;
         m_last       <= 1'b0;
         out_end      <= 1'b0;
      end else begin
         done     <= 1'b0;
         rd_start <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (sector_count == 16'd0) begin
                     done <= 1'b1;
                  end else begin
                     state       <= RUN;
                     busy        <= 1'b1;
                     first_r     <= first_sector;
                     count_r     <= sector_count;
                     issued      <= '0;
                     fetched     <= '0;
                     outstanding <= 1'b0;
                     wr_bank     <= '0;
                     fetch_bank  <= '0;
                     fetch_addr  <= '0;
                     occupancy   <= '0;
                     ready_cnt   <= '0;
                  end
               end
            end

            RUN: begin
               if (abort) begin
                  occupancy <= '0;
                  ready_cnt <= '0;
                  m_valid   <= 1'b0;
                  m_sos     <= 1'b0;
                  m_last    <= 1'b0;
                  out_end   <= 1'b0;
                  if (outstanding && !rd_done) begin
                     state <= ABORT_WAIT;
                  end else begin
                     state       <= IDLE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     outstanding <= 1'b0;
                  end
               end else if (last_hs) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  m_valid   <= 1'b0;
                  m_sos     <= 1'b0;
                  m_last    <= 1'b0;
                  out_end   <= 1'b0;
                  occupancy <= '0;
                  ready_cnt <= '0;
               end else begin
                  if (issue_ok) begin
                     rd_start     <= 1'b1;
                     outstanding  <= 1'b1;
                     rd_sector_no <= first_r + 32'(issued);
                     issued       <= issued + 16'd1;
                  end
                  if (fill_done) begin
                     outstanding <= 1'b0;
                     wr_bank     <= bank_inc(wr_bank);
                  end
                  occupancy <= occupancy + {2'b00, fill_done} - {2'b00, bank_freed};
                  ready_cnt <= ready_cnt + {2'b00, fill_done} - {2'b00, fetch_end};
                  if (fetch) begin
                     m_valid    <= 1'b1;
                     m_sos      <= (fetch_addr == '0);
                     m_last     <= (fetch_addr == LAST_BYTE) && (fetched == count_r - 16'd1);
                     out_end    <= (fetch_addr == LAST_BYTE);
                     fetch_addr <= fetch_addr + 1'b1;
                     if (fetch_addr == LAST_BYTE) begin
                        fetch_bank <= bank_inc(fetch_bank);
                        fetched    <= fetched + 16'd1;
                     end
                  end else if (handshake) begin
                     m_valid <= 1'b0;
                     m_sos   <= 1'b0;
                     m_last  <= 1'b0;
                     out_end <= 1'b0;
                  end
               end
            end

            ABORT_WAIT: begin
               if (rd_done) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  outstanding <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Self-checking bench for sd_sector_streamer: a behavioural SD reader fills
// sectors with byte = addr ^ sector[7:0]; a scoreboard holds the expected byte
// stream and sector numbers, and a monitor compares every handshake.
module tb_sd_sector_streamer;

   localparam int BANKS = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] first_sector;
   logic [15:0] sector_count;
   logic        abort;
   logic        busy;
   logic        done;
   logic        rd_start;
   logic [31:0] rd_sector_no;
   logic        rd_busy;
   logic        rd_done;
   logic        in_req;
   logic [8:0]  in_addr;
   logic [7:0]  in_byte;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_sos;
   logic        m_last;

   typedef struct packed {
      logic [7:0] data;
      logic       sos;
      logic       last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] sec_q[$];

   int checks       = 0;
   int errors       = 0;
   int rd_start_cnt = 0;
   int done_cnt     = 0;
   int reads_seen   = 0;
   int bytes_written = 0;
   int bytes_seen   = 0;
   int ready_mode   = 0;

   sd_sector_streamer #(.BANKS(BANKS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .first_sector (first_sector),
      .sector_count (sector_count),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .rd_start     (rd_start),
      .rd_sector_no (rd_sector_no),
      .rd_busy      (rd_busy),
      .rd_done      (rd_done),
      .in_req       (in_req),
      .in_addr      (in_addr),
      .in_byte      (in_byte),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_sos        (m_sos),
      .m_last       (m_last)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: the whole expected job is derived up front from the
   // sector numbering and fill pattern, then start is pulsed.
   task automatic apply_stimulus(input logic [31:0] f, input logic [15:0] c);
      logic [31:0] sn;
      beat_t       b;
      for (int s = 0; s < int'(c); s++) begin
         sn = f + 32'(s);
         sec_q.push_back(sn);
         for (int a = 0; a < 512; a++) begin
            b.data = 8'(a) ^ sn[7:0];
            b.sos  = (a == 0);
            b.last = (s == int'(c) - 1) && (a == 511);
            exp_q.push_back(b);
         end
      end
      @(posedge clk); #1;
      start = 1'b1; first_sector = f; sector_count = c;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check_output({name, "_done_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic finish_job(input string name, input int base_rd, input int base_done, input int reads);
      repeat (4) @(negedge clk);
      check_output({name, "_rd_starts"}, 64'(rd_start_cnt - base_rd), 64'(reads));
      check_output({name, "_done_pulses"}, 64'(done_cnt - base_done), 64'd1);
      check_output({name, "_bytes_left"}, 64'(exp_q.size()), 64'd0);
      check_output({name, "_sectors_left"}, 64'(sec_q.size()), 64'd0);
   endtask

   task automatic pulse_abort();
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
   endtask

   // Sink ready pattern: 0 = always ready, 1 = random 50%, 2 = stalled.
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
         endcase
      end
   end

   // Behavioural SD reader: serves each rd_start with 512 bytes (random gaps)
   // followed by an rd_done pulse; gives up silently on reset.
   logic [31:0] cur_sec;
   bit          rd_alive;
   initial begin
      rd_busy = 1'b0; rd_done = 1'b0; in_req = 1'b0; in_addr = '0; in_byte = '0;
      forever begin
         @(negedge clk);
         if (rst_n && rd_start) begin
            cur_sec = rd_sector_no;
            if (sec_q.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL unexpected_rd_start: got sector 0x%0h, expected none", rd_sector_no);
            end else begin
               check_output("rd_sector_no", 64'(rd_sector_no), 64'(sec_q.pop_front()));
            end
            reads_seen++;
            bytes_written = 0;
            rd_alive = 1'b1;
            @(posedge clk); #1;
            rd_busy = 1'b1;
            for (int a = 0; a < 512 && rd_alive; a++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
               if (!rst_n) begin
                  rd_alive = 1'b0;
               end else begin
                  in_req = 1'b1; in_addr = 9'(a); in_byte = 8'(a) ^ cur_sec[7:0];
                  @(posedge clk); #1;
                  in_req = 1'b0;
                  bytes_written = a + 1;
                  if (!rst_n) rd_alive = 1'b0;
               end
            end
            rd_busy = 1'b0;
            if (rd_alive) begin
               check_output("rd_sector_hold", 64'(rd_sector_no), 64'(cur_sec));
               rd_done = 1'b1;
               @(posedge clk); #1;
               rd_done = 1'b0;
            end
         end
      end
   end

   // Monitor: scoreboard pops on every handshake, stall stability, event counts.
   beat_t      e;
   logic       prev_stall = 1'b0;
   logic       prev_abort = 1'b0;
   logic [7:0] pd;
   logic       ps, pl;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && prev_stall && !prev_abort)
            check_output("stall_hold", 64'({m_valid, m_data, m_sos, m_last}), 64'({1'b1, pd, ps, pl}));
         if (rd_start) rd_start_cnt++;
         if (done) done_cnt++;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", m_data);
            end else begin
               e = exp_q.pop_front();
               check_output("stream_beat", 64'({m_data, m_sos, m_last}), 64'({e.data, e.sos, e.last}));
               bytes_seen++;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_abort = abort;
         pd = m_data; ps = m_sos; pl = m_last;
      end
   end

   // Safety net so the run always ends.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   int          base_rd, base_done, base_bytes, lat, cnt;
   bit          got, early;
   logic [31:0] rnd;

   // Test sequence.
   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; first_sector = '0; sector_count = '0;
      repeat (3) @(negedge clk);
      check_output("reset_ctrl", 64'({busy, done, rd_start, m_valid, m_sos, m_last}), 64'd0);
      check_output("reset_rd_sector_no", 64'(rd_sector_no), 64'd0);
      check_output("reset_m_data", 64'(m_data), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Abort while idle has no effect.
      base_done = done_cnt;
      pulse_abort();
      repeat (3) @(negedge clk);
      check_output("idle_abort_ignored", 64'({busy, 32'(done_cnt - base_done)}), 64'd0);

      // Job A: 100..102 with an always-ready sink, plus latency and throughput.
      ready_mode = 0; base_rd = rd_start_cnt; base_done = done_cnt;
      apply_stimulus(32'd100, 16'd3);
      @(negedge clk);
      check_output("jobA_busy", 64'(busy), 64'd1);
      got = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (rd_done) begin got = 1'b1; break; end
         @(negedge clk);
      end
      check_output("jobA_first_rd_done", 64'(got), 64'd1);
      lat = 0;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         if (m_valid) begin lat = i; break; end
      end
      check_output("jobA_first_valid_within_2", 64'(lat != 0), 64'd1);
      cnt = 0;
      if (lat != 0) begin
         for (int i = 0; i < 512; i++) begin
            if (m_valid && m_ready) cnt++;
            @(negedge clk);
         end
      end
      check_output("jobA_throughput", 64'(cnt), 64'd512);
      wait_done(8000, "jobA");
      finish_job("jobA", base_rd, base_done, 3);

      // Job B: sector number wraps through zero, random ready.
      ready_mode = 1; base_rd = rd_start_cnt; base_done = done_cnt;
      apply_stimulus(32'hFFFF_FFFF, 16'd2);
      wait_done(10000, "jobB");
      finish_job("jobB", base_rd, base_done, 2);

      // Job C: stalled sink only lets two banks fill, then drains cleanly.
      ready_mode = 2; base_rd = rd_start_cnt; base_done = done_cnt;
      apply_stimulus(32'd5000, 16'd4);
      repeat (2500) @(negedge clk);
      check_output("jobC_stalled_rd_starts", 64'(rd_start_cnt - base_rd), 64'd2);
      ready_mode = 1;
      wait_done(20000, "jobC");
      finish_job("jobC", base_rd, base_done, 4);

      // Job D: random first sector, a start mid-job must be ignored.
      ready_mode = 1; base_rd = rd_start_cnt; base_done = done_cnt; base_bytes = bytes_seen;
      rnd = $urandom;
      apply_stimulus(rnd, 16'd3);
      for (int i = 0; i < 4000 && bytes_seen < base_bytes + 300; i++) @(negedge clk);
      @(posedge clk); #1;
      start = 1'b1; first_sector = 32'd7; sector_count = 16'd9;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(15000, "jobD");
      finish_job("jobD", base_rd, base_done, 3);

      // Zero-length job.
      base_rd = rd_start_cnt; base_done = done_cnt;
      apply_stimulus(32'h1234, 16'd0);
      @(negedge clk);
      check_output("zero_done_next_cycle", 64'({done, busy}), 64'b10);
      repeat (5) @(negedge clk);
      check_output("zero_no_rd_start", 64'(rd_start_cnt - base_rd), 64'd0);
      check_output("zero_one_done", 64'(done_cnt - base_done), 64'd1);

      // Abort in the middle of reading sector 2 of 5.
      ready_mode = 0; base_rd = rd_start_cnt; base_done = done_cnt;
      reads_seen = 0;
      apply_stimulus(32'd300, 16'd5);
      got = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (reads_seen == 3 && bytes_written >= 100) begin got = 1'b1; break; end
      end
      check_output("abort_reached_sector2", 64'(got), 64'd1);
      pulse_abort();
      exp_q.delete();
      sec_q.delete();
      @(negedge clk);
      check_output("abort_wait_state", 64'({m_valid, done, busy}), 64'b001);
      got = 1'b0; early = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (rd_done) begin got = 1'b1; break; end
         if (done) early = 1'b1;
         @(negedge clk);
      end
      check_output("abort_rd_done_seen", 64'(got), 64'd1);
      check_output("abort_no_early_done", 64'(early), 64'd0);
      @(negedge clk);
      check_output("abort_done_pulse", 64'({done, m_valid}), 64'b10);
      repeat (50) @(negedge clk);
      check_output("abort_rd_starts", 64'(rd_start_cnt - base_rd), 64'd3);
      check_output("abort_one_done", 64'(done_cnt - base_done), 64'd1);
      check_output("abort_idle", 64'({busy, m_valid}), 64'd0);

      // Reset mid-job, then a fresh job must run normally.
      ready_mode = 0; base_bytes = bytes_seen;
      apply_stimulus(32'd900, 16'd3);
      for (int i = 0; i < 5000 && bytes_seen < base_bytes + 700; i++) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check_output("midreset_ctrl", 64'({busy, done, rd_start, m_valid, m_sos, m_last}), 64'd0);
      check_output("midreset_rd_sector_no", 64'(rd_sector_no), 64'd0);
      check_output("midreset_m_data", 64'(m_data), 64'd0);
      exp_q.delete();
      sec_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      ready_mode = 1; base_rd = rd_start_cnt; base_done = done_cnt;
      rnd = $urandom;
      apply_stimulus(rnd, 16'd1);
      wait_done(6000, "postreset");
      finish_job("postreset", base_rd, base_done, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
